// File: rtl/reg_driver.sv
// Stimulus sequencer and self-checker for an enabled register with sync reset.
// Optional stop-on-first-error behaviour and fail_phase output: define REG_DRV_STOP_ON_ERR_EN.
module reg_driver #(
  parameter int unsigned D_BIT    = 8,
  parameter int unsigned RST_CYC  = 2,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned N_RAND   = 32,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_rst,
  output logic             dut_en,
  output logic [D_BIT-1:0] dut_d,
  input  logic [D_BIT-1:0] dut_q,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_cnt,
  output logic             pass
`ifdef REG_DRV_STOP_ON_ERR_EN
  ,
  output logic [2:0]       fail_phase
`endif
);

  localparam int unsigned MAX_A   = (RST_CYC > D_BIT) ? RST_CYC : D_BIT;
  localparam int unsigned MAX_B   = (HOLD_CYC > N_RAND) ? HOLD_CYC : N_RAND;
  localparam int unsigned MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_WALK  = 3'd2,
    S_HOLD  = 3'd3,
    S_RAND  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [D_BIT-1:0]   gold_q, gold_d;
  logic               chk_q, chk_d;
  logic               dut_rst_q, dut_rst_d;
  logic               dut_en_q, dut_en_d;
  logic [D_BIT-1:0]   dut_d_q, dut_d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        err_q, err_d;
  logic               pass_q, pass_d;
  logic               start_ok;
  logic               sampling;
  logic               mismatch;
  logic               lfsr_fb;
`ifdef REG_DRV_STOP_ON_ERR_EN
  logic [2:0]         fail_phase_q, fail_phase_d;
  logic [2:0]         chk_phase_q, chk_phase_d;
`endif

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sampling = (state_q == S_RST) || (state_q == S_WALK) ||
                    (state_q == S_HOLD) || (state_q == S_RAND);
  assign mismatch = chk_q && (dut_q != gold_q);
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Next state, golden model, error count and the registered drive values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    lfsr_d    = lfsr_q;
    gold_d    = gold_q;
    chk_d     = chk_q;
    err_d     = err_q;
    dut_rst_d = 1'b0;
    dut_en_d  = 1'b0;
    dut_d_d   = '0;
`ifdef REG_DRV_STOP_ON_ERR_EN
    fail_phase_d = fail_phase_q;
    chk_phase_d  = chk_phase_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        cnt_d = '0;
        if (start) state_d = S_RST;
      end
      S_RST:  if (cnt_q == CNT_W'(RST_CYC - 1))  begin state_d = S_WALK;  cnt_d = '0; end
      S_WALK: if (cnt_q == CNT_W'(D_BIT - 1))    begin state_d = S_HOLD;  cnt_d = '0; end
      S_HOLD: if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin state_d = S_RAND;  cnt_d = '0; end
      S_RAND: if (cnt_q == CNT_W'(N_RAND - 1))   begin state_d = S_DRAIN; cnt_d = '0; end
      S_DRAIN: begin
        state_d = S_DONE;
        cnt_d   = '0;
        chk_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Golden register tracks what the register under test sampled this edge.
    if (sampling) begin
      chk_d = 1'b1;
      if (dut_rst_q)     gold_d = '0;
      else if (dut_en_q) gold_d = dut_d_q;
    end

    if (start_ok) begin
      err_d  = '0;
      lfsr_d = SEED;
`ifdef REG_DRV_STOP_ON_ERR_EN
      fail_phase_d = '0;
    end else if (mismatch && (err_q == 16'd0)) begin
      err_d        = 16'd1;
      fail_phase_d = chk_phase_q;
    end
    if (sampling) chk_phase_d = 3'(state_q);
    // A counted error ends the run on the following edge.
    if ((err_q != 16'd0) && (sampling || (state_q == S_DRAIN))) begin
      state_d = S_DONE;
      cnt_d   = '0;
      chk_d   = 1'b0;
    end
`else
    end else if (mismatch && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
`endif

    if (state_d == S_RAND) lfsr_d = {lfsr_q[14:0], lfsr_fb};

    case (state_d)
      S_RST:  dut_rst_d = 1'b1;
      S_WALK: begin
        dut_en_d = 1'b1;
        dut_d_d  = D_BIT'(1) << cnt_d;
      end
      S_HOLD: dut_d_d = ~gold_d;
      S_RAND: begin
        dut_rst_d = (lfsr_d[3:0] == 4'hF);
        dut_en_d  = lfsr_d[15];
        dut_d_d   = lfsr_d[D_BIT-1:0];
      end
      default: ;
    endcase
  end

  assign busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  assign done_d = (state_d == S_DONE);
  assign pass_d = done_d && (err_d == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= SEED;
      gold_q    <= '0;
      chk_q     <= 1'b0;
      err_q     <= '0;
      dut_rst_q <= 1'b0;
      dut_en_q  <= 1'b0;
      dut_d_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef REG_DRV_STOP_ON_ERR_EN
      fail_phase_q <= '0;
      chk_phase_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      gold_q    <= gold_d;
      chk_q     <= chk_d;
      err_q     <= err_d;
      dut_rst_q <= dut_rst_d;
      dut_en_q  <= dut_en_d;
      dut_d_q   <= dut_d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
`ifdef REG_DRV_STOP_ON_ERR_EN
      fail_phase_q <= fail_phase_d;
      chk_phase_q  <= chk_phase_d;
`endif
    end
  end

  assign dut_rst = dut_rst_q;
  assign dut_en  = dut_en_q;
  assign dut_d   = dut_d_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = err_q;
  assign pass    = pass_q;
`ifdef REG_DRV_STOP_ON_ERR_EN
  assign fail_phase = fail_phase_q;
`endif

endmodule

// File: tb/tb_reg_driver.sv
// Directed bench for reg_driver: drives a behavioural register (ideal, bit0 stuck, ignores en).
module tb_reg_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dut_rst, dut_en;
  logic [7:0]  dut_d, dut_q;
  logic        busy, done, pass;
  logic [15:0] err_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          mode = 0;
  logic [7:0]  reg_q = 8'h00;
  logic [7:0]  traces [2][48];

  reg_driver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dut_rst (dut_rst),
    .dut_en  (dut_en),
    .dut_d   (dut_d),
    .dut_q   (dut_q),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .pass    (pass)
  );

  always #5 clk = ~clk;

  // Register under test; mode 2 models a register that ignores its enable.
  always_ff @(posedge clk) begin
    if (dut_rst)                    reg_q <= 8'h00;
    else if (dut_en || (mode == 2)) reg_q <= dut_d;
  end
  assign dut_q = (mode == 1) ? (reg_q & 8'hFE) : reg_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full run from an accepted start; k counts edges after the start edge E0.
  task automatic run(input int tr, input int dup_k,
                     input logic [15:0] e11, input logic [15:0] e12, input logic [15:0] e15);
    logic [15:0] m;
    logic [11:0] exp;
    m = 16'hACE1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("run%0d_err_clr", tr), err_cnt, 16'd0);
    check($sformatf("run%0d_pass_clr", tr), 16'(pass), 16'd0);
    for (int k = 0; k < 48; k++) begin
      if (k > 0) begin
        start = (k == dup_k);
        tick();
        start = 1'b0;
      end
      if (k < 2)        exp = {4'b1010, 8'h00};
      else if (k < 10)  exp = {4'b1001, 8'(8'h01 << (k - 2))};
      else if (k < 14)  exp = {4'b1000, 8'h7F};
      else if (k < 46) begin
        m   = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        exp = {2'b10, (m[3:0] == 4'hF), m[15], m[7:0]};
      end
      else if (k == 46) exp = {4'b1000, 8'h00};
      else              exp = {4'b0100, 8'h00};
      traces[tr][k] = dut_d;
      check($sformatf("run%0d_k%0d_outs", tr, k), 16'({busy, done, dut_rst, dut_en, dut_d}), 16'(exp));
      if (k == 11) check($sformatf("run%0d_err_k11", tr), err_cnt, e11);
      if (k == 12) check($sformatf("run%0d_err_k12", tr), err_cnt, e12);
      if (k == 15) check($sformatf("run%0d_err_k15", tr), err_cnt, e15);
    end
  endtask

  initial begin
    #12;
    check("reset_outs", 16'({busy, done, pass, dut_rst, dut_en, dut_d}), 16'd0);
    check("reset_err", err_cnt, 16'd0);
    rst_n = 1'b1;
    tick();

    // Ideal register, start from IDLE.
    mode = 0;
    run(0, -1, 16'd0, 16'd0, 16'd0);
    check("ideal_pass", 16'(pass), 16'd1);
    check("ideal_err", err_cnt, 16'd0);
    check("rand_first_d", 16'(traces[0][14]), 16'h00C3);
    check("rand_second_d", 16'(traces[0][15]), 16'h0087);
    repeat (3) tick();
    check("done_level", 16'({busy, done, pass}), 16'b011);

    // Enable-ignoring register, async reset taken in the RAND phase.
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check("midrun_err_before", err_cnt, 16'd4);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outs", 16'({busy, done, pass, dut_rst, dut_en, dut_d}), 16'd0);
    check("midrun_reset_err", err_cnt, 16'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // Rerun after reset with an extra start pulse during WALK.
    mode = 0;
    run(1, 4, 16'd0, 16'd0, 16'd0);
    check("rerun_pass", 16'(pass), 16'd1);
    for (int k = 0; k < 48; k++)
      check($sformatf("trace_k%0d", k), 16'(traces[1][k]), 16'(traces[0][k]));

    // Bit 0 stuck at zero: exactly one error from the WALK phase.
    mode = 1;
    run(0, -1, 16'd1, 16'd1, 16'd1);
    check("stuck_pass", 16'(pass), 16'd0);
    check("stuck_err_ge1", 16'(err_cnt >= 16'd1), 16'd1);

    // Enable ignored: every HOLD compare fails.
    mode = 2;
    run(0, -1, 16'd0, 16'd1, 16'd4);
    check("noen_pass", 16'(pass), 16'd0);
    check("noen_err_ge4", 16'(err_cnt >= 16'd4), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
